dcache_mem_stage_ctrl: RTL and testbench

MEM-stage front end sitting directly upstream of the data cache. It takes load/store requests from the EX/MEM pipeline register and drives the cache request port. It holds the request stable across a miss (refill and/or writeback), generates the pipeline stall, and returns load data to the MEM/WB register. It also runs a miss watchdog.

---
 rtl/dcache_mem_stage_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dcache_mem_stage_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_stage_ctrl.sv
// rtl/dcache_mem_stage_ctrl.sv - MEM-stage request/stall/response controller in front of the data cache
// Optional hit/miss statistics counters are built only when DCACHE_STAT_EN is defined.
module dcache_mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              cache_input_valid,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_mem_read,
    output logic              cache_mem_write,
    output logic [DATA_W-1:0] cache_din,
    input  logic              cache_ready,
    input  logic              cache_output_valid,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_dout,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err_timeout,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The watchdog compares against the low 8 bits only, matching the 8-bit busy counter.
    localparam logic [7:0] TIMEOUT_CMP = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [7:0]        busy_cnt_q, busy_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic op;
    logic done_hit;
    logic req_is_write;

    assign op           = req_valid && (req_read || req_write);
    assign done_hit     = cache_hit && cache_output_valid;
    // Read wins when both are set, so a write is only a write when read is low.
    assign req_is_write = req_write && !req_read;

    // Next-state and output decode; everything is forced to 0 while reset is asserted.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        read_d            = read_q;
        write_d           = write_q;
        busy_cnt_d        = busy_cnt_q;
        rdata_d           = rdata_q;
        err_d             = err_q;
        cache_input_valid = 1'b0;
        cache_addr        = '0;
        cache_mem_read    = 1'b0;
        cache_mem_write   = 1'b0;
        cache_din         = '0;
        stall             = 1'b0;
        rdata             = '0;
        rdata_valid       = 1'b0;
        err_timeout       = 1'b0;
        if (!reset) begin
            err_timeout = err_q;
            case (state_q)
                S_IDLE: begin
                    if (op) begin
                        cache_input_valid = cache_ready;
                        cache_addr        = req_addr;
                        cache_mem_read    = req_read;
                        cache_mem_write   = req_is_write;
                        cache_din         = req_wdata;
                        if (done_hit) begin
                            rdata_valid = 1'b1;
                            rdata       = req_read ? cache_dout : '0;
                        end else begin
                            stall      = 1'b1;
                            addr_d     = req_addr;
                            wdata_d    = req_wdata;
                            read_d     = req_read;
                            write_d    = req_is_write;
                            busy_cnt_d = '0;
                            state_d    = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Only the held copy reaches the cache so upstream changes cannot disturb the miss.
                    cache_input_valid = cache_ready;
                    cache_addr        = addr_q;
                    cache_mem_read    = read_q;
                    cache_mem_write   = write_q;
                    cache_din         = wdata_q;
                    stall             = 1'b1;
                    busy_cnt_d        = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;
                    if (busy_cnt_q == TIMEOUT_CMP) begin
                        err_d       = 1'b1;
                        err_timeout = 1'b1;
                    end
                    if (done_hit) begin
                        rdata_d = read_q ? cache_dout : '0;
                        state_d = S_RESP;
                    end
                end
                S_RESP: begin
                    rdata_valid = 1'b1;
                    rdata       = rdata_q;
                    addr_d      = '0;
                    wdata_d     = '0;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    busy_cnt_d  = '0;
                    rdata_d     = '0;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, hold registers, watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            busy_cnt_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            read_q     <= read_d;
            write_q    <= write_d;
            busy_cnt_q <= busy_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

`ifdef DCACHE_STAT_EN
    logic        hit_inc;
    logic        miss_inc;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    assign hit_inc  = !reset && (state_q == S_IDLE) && op && done_hit;
    assign miss_inc = !reset && (state_q == S_IDLE) && op && !done_hit;

    // Free-running wrap-around hit/miss statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_mem_stage_ctrl.sv
// tb/tb_dcache_mem_stage_ctrl.sv - directed self-checking bench for dcache_mem_stage_ctrl
module tb_dcache_mem_stage_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        cache_input_valid;
    logic [31:0] cache_addr;
    logic        cache_mem_read;
    logic        cache_mem_write;
    logic [31:0] cache_din;
    logic        cache_ready;
    logic        cache_output_valid;
    logic        cache_hit;
    logic [31:0] cache_dout;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err_timeout;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks;
    int errors;

    dcache_mem_stage_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(10)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .cache_input_valid (cache_input_valid),
        .cache_addr        (cache_addr),
        .cache_mem_read    (cache_mem_read),
        .cache_mem_write   (cache_mem_write),
        .cache_din         (cache_din),
        .cache_ready       (cache_ready),
        .cache_output_valid(cache_output_valid),
        .cache_hit         (cache_hit),
        .cache_dout        (cache_dout),
        .stall             (stall),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .err_timeout       (err_timeout),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; callers then drive inputs and wait #4 to sample.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
    int          stall_cycles;
    int          busy_bad;
    int          first_err;
    int          err_drop;

    initial begin
        checks = 0;
        errors = 0;
`ifdef DCACHE_STAT_EN
        exp_hits = 32'd1;
        exp_miss = 32'd1;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        reset = 1'b1; req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0;
        cache_ready = 1'b1; cache_output_valid = 1'b0; cache_hit = 1'b0; cache_dout = 32'h0;

        // Reset held two cycles with a live request: everything must read zero.
        cyc; cyc; #4;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_civ", {31'd0, cache_input_valid}, 32'd0);
        chk("rst_addr", cache_addr, 32'd0);
        chk("rst_mrd", {31'd0, cache_mem_read}, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
        cyc; reset = 1'b0; req_valid = 1'b0; #4;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_civ", {31'd0, cache_input_valid}, 32'd0);

        // Zero-latency load hit.
        cyc; req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h40;
        cache_hit = 1'b1; cache_output_valid = 1'b1; cache_dout = 32'hDEADBEEF; #4;
        chk("hit_stall", {31'd0, stall}, 32'd0);
        chk("hit_rvalid", {31'd0, rdata_valid}, 32'd1);
        chk("hit_rdata", rdata, 32'hDEADBEEF);
        chk("hit_civ", {31'd0, cache_input_valid}, 32'd1);
        chk("hit_addr", cache_addr, 32'h40);
        chk("hit_mrd", {31'd0, cache_mem_read}, 32'd1);
        cyc; req_valid = 1'b0; cache_hit = 1'b0; cache_output_valid = 1'b0; #4;
        chk("hit_count", hit_count, exp_hits);
        chk("post_hit_rvalid", {31'd0, rdata_valid}, 32'd0);

        // Load miss: one IDLE stall cycle plus 50 BUSY cycles, address changing upstream.
        cyc; req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h40; cache_dout = 32'h0BADF00D; #4;
        stall_cycles = stall ? 1 : 0;
        busy_bad = 0;
        chk("miss_rvalid", {31'd0, rdata_valid}, 32'd0);
        for (int i = 1; i <= 50; i++) begin
            cyc; req_addr = 32'h80;
            if (i == 50) begin
                cache_hit = 1'b1; cache_output_valid = 1'b1; cache_dout = 32'hCAFEF00D;
            end
            #4;
            if (stall) stall_cycles++;
            if (cache_addr !== 32'h40 || cache_input_valid !== 1'b1 || cache_mem_read !== 1'b1
                || rdata_valid !== 1'b0) busy_bad++;
        end
        chk("miss_stall_cycles", stall_cycles, 32'd51);
        chk("miss_busy_ports", busy_bad, 32'd0);
        cyc; cache_hit = 1'b0; cache_output_valid = 1'b0; cache_dout = 32'h0; #4;
        chk("resp_stall", {31'd0, stall}, 32'd0);
        chk("resp_rvalid", {31'd0, rdata_valid}, 32'd1);
        chk("resp_rdata", rdata, 32'hCAFEF00D);
        chk("resp_civ", {31'd0, cache_input_valid}, 32'd0);
        chk("resp_mrd", {31'd0, cache_mem_read}, 32'd0);
        chk("resp_addr", cache_addr, 32'd0);
        chk("miss_count", miss_count, exp_miss);
        cyc; req_valid = 1'b0; #4;
        chk("post_resp_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("post_resp_rdata", rdata, 32'd0);

        // Clear the sticky error raised by the long miss above.
        cyc; reset = 1'b1;
        cyc; reset = 1'b0; #4;
        chk("rst2_err", {31'd0, err_timeout}, 32'd0);

        // Store miss at 0x100.
        cyc; req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_addr = 32'h100; req_wdata = 32'h12345678; #4;
        chk("st_idle_stall", {31'd0, stall}, 32'd1);
        cyc; req_wdata = 32'h0; req_addr = 32'h200; #4;
        chk("st_busy_mwr", {31'd0, cache_mem_write}, 32'd1);
        chk("st_busy_mrd", {31'd0, cache_mem_read}, 32'd0);
        chk("st_busy_din", cache_din, 32'h12345678);
        chk("st_busy_addr", cache_addr, 32'h100);
        cyc; #4;
        chk("st_busy2_din", cache_din, 32'h12345678);
        cyc; cache_hit = 1'b1; cache_output_valid = 1'b1; cache_dout = 32'hFFFFFFFF; #4;
        chk("st_busy3_stall", {31'd0, stall}, 32'd1);
        cyc; cache_hit = 1'b0; cache_output_valid = 1'b0; #4;
        chk("st_resp_rvalid", {31'd0, rdata_valid}, 32'd1);
        chk("st_resp_rdata", rdata, 32'd0);
        chk("st_resp_mwr", {31'd0, cache_mem_write}, 32'd0);
        chk("st_resp_din", cache_din, 32'd0);
        chk("st_resp_civ", {31'd0, cache_input_valid}, 32'd0);
        cyc; req_valid = 1'b0; req_write = 1'b0; #4;

        // Watchdog with TIMEOUT=10 and a cache that never hits.
        cyc; req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h300; #4;
        first_err = -1;
        err_drop = 0;
        for (int k = 0; k < 20; k++) begin
            cyc; #4;
            if (err_timeout === 1'b1 && first_err < 0) first_err = k;
            if (first_err >= 0 && err_timeout !== 1'b1) err_drop++;
        end
        chk("wd_first_err_cycle", first_err, 32'd10);
        chk("wd_err_sticky", err_drop, 32'd0);
        chk("wd_stall", {31'd0, stall}, 32'd1);
        chk("wd_err_end", {31'd0, err_timeout}, 32'd1);
        cyc; reset = 1'b1; req_valid = 1'b0; #4;
        cyc; #4;
        chk("wd_rst_err", {31'd0, err_timeout}, 32'd0);
        chk("wd_rst_stall", {31'd0, stall}, 32'd0);
        cyc; reset = 1'b0; #4;
        chk("wd_rel_err", {31'd0, err_timeout}, 32'd0);

        // Reset in the middle of a BUSY miss abandons it.
        cyc; req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h400; #4;
        cyc; #4;
        chk("mid_busy_stall", {31'd0, stall}, 32'd1);
        cyc; reset = 1'b1; #4;
        cyc; reset = 1'b0; req_valid = 1'b0; #4;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_civ", {31'd0, cache_input_valid}, 32'd0);
        chk("mid_rst_addr", cache_addr, 32'd0);
        chk("mid_rst_mrd", {31'd0, cache_mem_read}, 32'd0);
        chk("mid_rst_rvalid", {31'd0, rdata_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
